// File: rtl/nes_joypad_reader.sv
// NES serial joypad initiator: latch, 8 shift pulses, one button byte per scan.
// Request to o_valid is 1+19T cycles; requests arriving mid-scan merge into one pending rescan.
module nes_joypad_reader #(
  parameter int C_clk_hz  = 21477272,
  parameter int C_half_us = 6,
  parameter int C_poll_hz = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_poll,
  input  logic       joy_data,
  output logic       joy_strobe,
  output logic       joy_clock,
  output logic [7:0] o_buttons,
  output logic       o_present,
  output logic       o_valid,
  output logic       o_busy
);

  localparam longint T_L = (longint'(C_clk_hz) * longint'(C_half_us)) / 64'd1000000;
  localparam int T  = int'(T_L);
  localparam int P  = (C_poll_hz > 0) ? C_clk_hz / ((C_poll_hz > 0) ? C_poll_hz : 1) : 2;
  localparam int CW = $clog2(2 * T);
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [CW-1:0] HALF_LAST  = CW'(T - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * T - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(P - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP,
    S_HI,
    S_LO,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      pulse;
  logic [7:0]      raw;
  logic [PW-1:0]   poll_cnt;
  logic            pending;
  logic            sync1;
  logic            sync2;
  logic            auto_req;
  logic            req;

  // Pad data is asynchronous to clock; no reset so it never gates the flops.
  always_ff @(posedge clock) begin
    sync1 <= joy_data;
    sync2 <= sync1;
  end

  assign auto_req = (C_poll_hz > 0) && (poll_cnt == POLL_LAST);
  assign req      = i_poll | auto_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pulse      <= '0;
      raw        <= '0;
      poll_cnt   <= '0;
      pending    <= 1'b0;
      joy_strobe <= 1'b0;
      joy_clock  <= 1'b0;
      o_buttons  <= '0;
      o_present  <= 1'b0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (C_poll_hz > 0) poll_cnt <= auto_req ? '0 : poll_cnt + 1'b1;
      if (state != S_IDLE) pending <= pending | req;

      case (state)
        S_IDLE: begin
          if (req || pending) begin
            state      <= S_LATCH;
            cnt        <= '0;
            joy_strobe <= 1'b1;
            o_busy     <= 1'b1;
            pending    <= 1'b0;
          end
        end
        S_LATCH: begin
          if (cnt == LATCH_LAST) begin
            state      <= S_GAP;
            cnt        <= '0;
            joy_strobe <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == HALF_LAST) begin
            raw[0]    <= sync2;
            state     <= S_HI;
            cnt       <= '0;
            pulse     <= 4'd1;
            joy_clock <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HI: begin
          if (cnt == HALF_LAST) begin
            state     <= S_LO;
            cnt       <= '0;
            joy_clock <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LO: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // Ninth bit is the pad's grounded serial input: low means a pad is attached.
            if (pulse == 4'd8) begin
              state     <= S_DONE;
              o_buttons <= ~raw;
              o_present <= ~sync2;
              o_valid   <= 1'b1;
              o_busy    <= 1'b0;
            end else begin
              raw[pulse[2:0]] <= sync2;
              pulse           <= pulse + 1'b1;
              state           <= S_HI;
              joy_clock       <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_joypad_reader.sv
// Directed bench: T=4 manual-poll instance with a pad model, plus a T=2 / P=200 autopoll instance.
module tb_nes_joypad_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       i_poll = 1'b0;
  logic [7:0] pad_mask = 8'h00;
  logic       pad_on = 1'b1;
  logic       joy_data;
  logic       joy_strobe, joy_clock, o_present, o_valid, o_busy;
  logic [7:0] o_buttons;

  logic       poll2 = 1'b0;
  logic       data2 = 1'b1;
  logic       strobe2, clk2, present2, valid2, busy2;
  logic [7:0] buttons2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pad_idx = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Pad model reads the live mask per bit, so a mid-scan mask change shows on later bits.
  always @(posedge joy_strobe or posedge joy_clock) begin
    if (joy_strobe) pad_idx <= 0;
    else            pad_idx <= pad_idx + 1;
  end
  logic [2:0] pad_bit;
  assign pad_bit  = pad_idx[2:0];
  assign joy_data = !pad_on ? 1'b1 : (pad_idx < 8) ? ~pad_mask[pad_bit] : 1'b0;

  nes_joypad_reader #(.C_clk_hz(4000000), .C_half_us(1), .C_poll_hz(0)) dut (
    .clock(clock), .reset(reset), .i_poll(i_poll), .joy_data(joy_data),
    .joy_strobe(joy_strobe), .joy_clock(joy_clock), .o_buttons(o_buttons),
    .o_present(o_present), .o_valid(o_valid), .o_busy(o_busy)
  );

  nes_joypad_reader #(.C_clk_hz(2000000), .C_half_us(1), .C_poll_hz(10000)) dut2 (
    .clock(clock), .reset(reset), .i_poll(poll2), .joy_data(data2),
    .joy_strobe(strobe2), .joy_clock(clk2), .o_buttons(buttons2),
    .o_present(present2), .o_valid(valid2), .o_busy(busy2)
  );

  task automatic poll_once(output int t0);
    @(negedge clock);
    i_poll = 1'b1;
    t0 = cyc;
    @(negedge clock);
    i_poll = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int at, output bit seen);
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (o_valid) begin
        seen = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({joy_strobe, joy_clock, o_buttons, o_present, o_valid, o_busy} !== 13'h0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0", {joy_strobe, joy_clock, o_buttons, o_present, o_valid, o_busy});
    end
    checks++;
    if ({strobe2, clk2, buttons2, present2, valid2, busy2} !== 13'h0) begin
      errors++;
      $display("FAIL reset_state2: got %b want 0", {strobe2, clk2, buttons2, present2, valid2, busy2});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_scan();
    int t0, vat, nvalid, strobe_hi, pulses;
    logic prev_clk;
    nvalid = 0; strobe_hi = 0; pulses = 0; vat = -1; prev_clk = 1'b0;
    pad_on = 1'b1;
    pad_mask = 8'hA5;
    @(negedge clock);
    i_poll = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clock);
      if (i == 1) begin
        i_poll = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || joy_strobe !== 1'b1) begin
          errors++;
          $display("FAIL scan_start: busy=%b strobe=%b want 1 1", o_busy, joy_strobe);
        end
      end
      if (joy_strobe) strobe_hi++;
      if (joy_clock && !prev_clk) pulses++;
      prev_clk = joy_clock;
      if (o_valid) begin
        nvalid++;
        vat = cyc;
      end
    end
    checks++;
    if (nvalid != 1 || vat != t0 + 77) begin
      errors++;
      $display("FAIL scan_latency: valid count=%0d at=%0d want 1 at %0d", nvalid, vat, t0 + 77);
    end
    checks++;
    if (o_buttons !== 8'hA5 || o_present !== 1'b1) begin
      errors++;
      $display("FAIL scan_data: buttons=%h present=%b want a5 1", o_buttons, o_present);
    end
    checks++;
    if (strobe_hi != 8) begin
      errors++;
      $display("FAIL strobe_width: got %0d want 8", strobe_hi);
    end
    checks++;
    if (pulses != 8) begin
      errors++;
      $display("FAIL clock_pulses: got %0d want 8", pulses);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b want 0", o_busy);
    end
  endtask

  task automatic test_absent();
    int t0, at, extra;
    bit seen;
    pad_on = 1'b0;
    poll_once(t0);
    wait_valid(120, at, seen);
    checks++;
    if (!seen || o_buttons !== 8'h00 || o_present !== 1'b0) begin
      errors++;
      $display("FAIL absent_pad: seen=%0d buttons=%h present=%b want 1 00 0", seen, o_buttons, o_present);
    end
    extra = 0;
    repeat (60) begin
      @(negedge clock);
      if (o_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL absent_single_valid: extra valids=%0d want 0", extra);
    end
    pad_on = 1'b1;
  endtask

  task automatic test_all_pressed();
    int t0, at;
    bit seen;
    pad_mask = 8'hFF;
    poll_once(t0);
    wait_valid(120, at, seen);
    checks++;
    if (!seen || o_buttons !== 8'hFF || o_present !== 1'b1) begin
      errors++;
      $display("FAIL all_pressed: seen=%0d buttons=%h present=%b want 1 ff 1", seen, o_buttons, o_present);
    end
  endtask

  task automatic test_back_to_back();
    int t0, nrise, nvalid, r1, r2, v1, v2;
    logic prev_s;
    nrise = 0; nvalid = 0; r1 = -1; r2 = -1; v1 = -1; v2 = -1; prev_s = 1'b0;
    pad_mask = 8'h3C;
    @(negedge clock);
    i_poll = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clock);
      i_poll = (i == 10 || i == 20 || i == 30);
      if (joy_strobe && !prev_s) begin
        nrise++;
        if (nrise == 1) r1 = cyc; else r2 = cyc;
      end
      prev_s = joy_strobe;
      if (o_valid) begin
        nvalid++;
        if (nvalid == 1) v1 = cyc; else v2 = cyc;
      end
    end
    i_poll = 1'b0;
    checks++;
    if (nrise != 2 || nvalid != 2) begin
      errors++;
      $display("FAIL merged_requests: scans=%0d valids=%0d want 2 2", nrise, nvalid);
    end
    checks++;
    if (r1 != t0 + 1 || r2 != v1 + 2 || v2 != r2 + 76) begin
      errors++;
      $display("FAIL rescan_timing: r1=%0d r2=%0d v1=%0d v2=%0d t0=%0d", r1, r2, v1, v2, t0);
    end
    checks++;
    if (o_buttons !== 8'h3C || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rescan_data: buttons=%h busy=%b want 3c 0", o_buttons, o_busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    int t0, nvalid;
    pad_mask = 8'h5A;
    poll_once(t0);
    while (cyc < t0 + 40) @(negedge clock);
    checks++;
    if (o_busy !== 1'b1 || joy_clock !== 1'b1) begin
      errors++;
      $display("FAIL pulse4_state: busy=%b clock=%b want 1 1", o_busy, joy_clock);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({joy_strobe, joy_clock, o_buttons, o_busy, o_valid} !== 12'h0) begin
      errors++;
      $display("FAIL mid_scan_reset: strobe=%b clock=%b buttons=%h busy=%b valid=%b want all 0",
               joy_strobe, joy_clock, o_buttons, o_busy, o_valid);
    end
    nvalid = 0;
    repeat (150) begin
      @(negedge clock);
      if (o_valid || o_busy) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL abort_no_valid: active cycles=%0d want 0", nvalid);
    end
  endtask

  task automatic test_mid_scan_change();
    int t0, at;
    bit seen;
    pad_mask = 8'h01;
    poll_once(t0);
    while (cyc < t0 + 16) @(negedge clock);
    pad_mask = 8'h80;
    wait_valid(120, at, seen);
    checks++;
    if (!seen || o_buttons !== 8'h81) begin
      errors++;
      $display("FAIL mask_change: seen=%0d buttons=%h want 1 81", seen, o_buttons);
    end
    poll_once(t0);
    wait_valid(120, at, seen);
    checks++;
    if (!seen || o_buttons !== 8'h80) begin
      errors++;
      $display("FAIL mask_next_scan: seen=%0d buttons=%h want 1 80", seen, o_buttons);
    end
  endtask

  task automatic test_autopoll();
    int nrise, last_rise, nvalid_between;
    logic prev_s;
    nrise = 0; last_rise = -1; nvalid_between = 0; prev_s = strobe2;
    for (int i = 0; i < 700; i++) begin
      @(negedge clock);
      if (strobe2 && !prev_s) begin
        if (nrise > 0) begin
          checks++;
          if (cyc - last_rise != 200 || nvalid_between != 1) begin
            errors++;
            $display("FAIL autopoll_period: interval=%0d valids=%0d want 200 1", cyc - last_rise, nvalid_between);
          end
        end
        nrise++;
        last_rise = cyc;
        nvalid_between = 0;
      end
      prev_s = strobe2;
      if (valid2) nvalid_between++;
    end
    checks++;
    if (nrise < 3 || buttons2 !== 8'h00 || present2 !== 1'b0) begin
      errors++;
      $display("FAIL autopoll_scans: rises=%0d buttons=%h present=%b want >=3 00 0", nrise, buttons2, present2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_absent();
    test_all_pressed();
    test_back_to_back();
    test_reset_mid_scan();
    test_mid_scan_change();
    test_autopoll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
